// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);

  // CPU load/store port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // Host/loader port
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  // Single-port memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              owner;
  logic              busy;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_ack, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner, busy
  );

  // Requester/memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_ack, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner, busy
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising CPU and host accesses to one data-memory port.
// Host lock keeps the CPU out; each access is IDLE -> ACCESS [-> WAIT] -> ACK.
// MEM_LAT must be 1..3.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned LAT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_we, w_we_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last_owner, w_last_owner_nxt;
  logic [LAT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic              r_mem_en, w_mem_en_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_host_ack, w_host_ack_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_host_rdata, w_host_rdata_nxt;
  logic              r_busy, w_busy_nxt;

  logic w_cpu_elig;
  logic w_host_elig;
  logic w_grant_host;

  // Eligibility and tie-break: on a tie the requester that did not win last goes next
  always_comb begin
    w_cpu_elig   = bus.cpu_req & ~bus.host_lock;
    w_host_elig  = bus.host_req;
    w_grant_host = w_host_elig & (~w_cpu_elig | ~r_last_owner);
  end

  // Next-state and next-output logic; outputs are registered one step ahead of the state
  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_lat_cnt_nxt    = r_lat_cnt;
    w_mem_en_nxt     = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_cpu_ack_nxt    = 1'b0;
    w_host_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt  = r_cpu_rdata;
    w_host_rdata_nxt = r_host_rdata;

    case (r_state)
      S_IDLE: begin
        if (w_cpu_elig | w_host_elig) begin
          w_state_nxt      = S_ACCESS;
          w_owner_nxt      = w_grant_host;
          w_last_owner_nxt = w_grant_host;
          w_mem_en_nxt     = 1'b1;
          if (w_grant_host) begin
            w_we_nxt        = bus.host_we;
            w_mem_we_nxt    = bus.host_we;
            w_mem_addr_nxt  = bus.host_addr;
            w_mem_wdata_nxt = bus.host_wdata;
          end else begin
            w_we_nxt        = bus.cpu_we;
            w_mem_we_nxt    = bus.cpu_we;
            w_mem_addr_nxt  = bus.cpu_addr;
            w_mem_wdata_nxt = bus.cpu_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (r_we) begin
          w_state_nxt    = S_ACK;
          w_cpu_ack_nxt  = ~r_owner;
          w_host_ack_nxt = r_owner;
        end else begin
          w_state_nxt   = S_WAIT;
          w_lat_cnt_nxt = LAT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_state_nxt    = S_ACK;
          w_cpu_ack_nxt  = ~r_owner;
          w_host_ack_nxt = r_owner;
          if (r_owner) begin
            w_host_rdata_nxt = bus.mem_rdata;
          end else begin
            w_cpu_rdata_nxt = bus.mem_rdata;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_lat_cnt    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_we         <= w_we_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_host_ack   <= w_host_ack_nxt;
      r_cpu_rdata  <= w_cpu_rdata_nxt;
      r_host_rdata <= w_host_rdata_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Output mapping; stall is the only combinational output
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_stall  = bus.cpu_req & ~r_cpu_ack;
  assign bus.host_ack   = r_host_ack;
  assign bus.host_rdata = r_host_rdata;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.owner      = r_owner;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b1 ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(16)) b3 ();

  dmem_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  // One-cycle synchronous RAM behind the MEM_LAT=1 instance
  logic [15:0] mem1 [1024];
  always @(posedge clk) begin
    if (b1.mem_en) begin
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      else           b1.mem_rdata      <= mem1[b1.mem_addr];
    end
  end

  // Three-stage read pipe behind the MEM_LAT=3 instance; data valid for one cycle only
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    if (b3.mem_en && !b3.mem_we)
      p3[0] <= (b3.mem_addr == 10'h3FF) ? 16'hBEEF : (16'h0A00 | {6'h0, b3.mem_addr});
    else
      p3[0] <= 16'h0000;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign b3.mem_rdata = p3[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single access on the MEM_LAT=1 instance; returns ticks to ack and mem_en count
  task automatic do_access(input bit h, input bit we, input logic [9:0] a,
                           input logic [15:0] d, output int lat, output int n_en);
    if (h) begin
      b1.host_req = 1'b1; b1.host_we = we; b1.host_addr = a; b1.host_wdata = d;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_addr = a; b1.cpu_wdata = d;
    end
    lat  = 0;
    n_en = 0;
    do begin
      tick();
      lat++;
      if (b1.mem_en) begin
        n_en++;
        chk("acc_mem_addr", b1.mem_addr, a);
        chk("acc_mem_we", b1.mem_we, we);
        if (we) chk("acc_mem_wdata", b1.mem_wdata, d);
      end
      if (!h) chk("acc_stall", b1.cpu_stall, b1.cpu_ack ? 1'b0 : 1'b1);
    end while (!(h ? b1.host_ack : b1.cpu_ack) && lat < 20);
    chk("acc_ack_excl", b1.cpu_ack & b1.host_ack, 0);
    b1.cpu_req  = 1'b0;
    b1.host_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat, n_en, t, k, en_cnt, last_ack_t, hacks, cacks, hs, te;

    reset = 1'b1;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.host_req = 0; b1.host_we = 0; b1.host_addr = '0; b1.host_wdata = '0; b1.host_lock = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
    b3.host_req = 0; b3.host_we = 0; b3.host_addr = '0; b3.host_wdata = '0; b3.host_lock = 0;
    tick(); tick();

    // Reset state
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_mem_we", b1.mem_we, 0);
    chk("rst_mem_addr", b1.mem_addr, 0);
    chk("rst_mem_wdata", b1.mem_wdata, 0);
    chk("rst_acks", {b1.cpu_ack, b1.host_ack}, 0);
    chk("rst_rdata", {b1.cpu_rdata, b1.host_rdata}, 0);
    chk("rst_owner", b1.owner, 0);
    chk("rst_busy", b1.busy, 0);
    reset = 1'b0;
    tick();

    // 1: CPU write then read back
    do_access(1'b0, 1'b1, 10'h005, 16'h1234, lat, n_en);
    chk("t1_wr_lat", lat, 2);
    chk("t1_wr_en", n_en, 1);
    do_access(1'b0, 1'b0, 10'h005, 16'h0000, lat, n_en);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_en", n_en, 1);
    chk("t1_rdata", b1.cpu_rdata, 16'h1234);

    // 2: both requesting continuously after reset -> CPU, host, CPU, host
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    b1.cpu_req  = 1; b1.cpu_we  = 1; b1.cpu_addr  = 10'h010; b1.cpu_wdata  = 16'hA0A0;
    b1.host_req = 1; b1.host_we = 1; b1.host_addr = 10'h020; b1.host_wdata = 16'h0B0B;
    k = 0; t = 0; en_cnt = 0; last_ack_t = 0;
    while (k < 4 && t < 40) begin
      tick();
      t++;
      if (b1.mem_en) begin
        en_cnt++;
        if (k > 0) chk("t2_idle_gap", t - last_ack_t, 2);
      end
      if (b1.cpu_ack || b1.host_ack) begin
        chk("t2_ack_excl", b1.cpu_ack & b1.host_ack, 0);
        chk("t2_order", b1.host_ack, k % 2);
        chk("t2_owner", b1.owner, k % 2);
        chk("t2_en_per_ack", en_cnt, 1);
        en_cnt = 0;
        last_ack_t = t;
        k++;
      end
    end
    chk("t2_grants", k, 4);
    b1.cpu_req = 0; b1.host_req = 0;
    tick(); tick();

    // 3: host lock starves CPU; release lets CPU in at next IDLE
    b1.host_lock = 1;
    b1.cpu_req  = 1; b1.cpu_we  = 0; b1.cpu_addr  = 10'h005;
    b1.host_req = 1; b1.host_we = 0; b1.host_addr = 10'h010;
    hacks = 0; cacks = 0; t = 0;
    while (hacks < 3 && t < 40) begin
      tick();
      t++;
      chk("t3_stall", b1.cpu_stall, 1);
      if (b1.cpu_ack) cacks++;
      if (b1.host_ack) begin
        hacks++;
        chk("t3_host_rdata", b1.host_rdata, 16'hA0A0);
      end
    end
    chk("t3_host_acks", hacks, 3);
    chk("t3_cpu_acks", cacks, 0);
    b1.host_lock = 0;
    t = 0;
    do begin
      tick();
      t++;
      chk("t3_no_host", b1.host_ack, 0);
    end while (!b1.cpu_ack && t < 20);
    chk("t3_cpu_lat", t, 4);
    chk("t3_cpu_rdata", b1.cpu_rdata, 16'h1234);
    chk("t3_owner", b1.owner, 0);
    b1.cpu_req = 0; b1.host_req = 0;
    tick();

    // 6: CPU read then CPU write held back-to-back; one IDLE cycle between
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 10'h005;
    t = 0;
    do begin tick(); t++; end while (!b1.cpu_ack && t < 20);
    chk("t6_rd_lat", t, 3);
    chk("t6_rd_data", b1.cpu_rdata, 16'h1234);
    b1.cpu_we = 1; b1.cpu_addr = 10'h006; b1.cpu_wdata = 16'h5678;
    tick();
    chk("t6_idle_busy", b1.busy, 0);
    chk("t6_idle_en", b1.mem_en, 0);
    tick();
    chk("t6_wr_en", {b1.mem_en, b1.mem_we}, 2'b11);
    chk("t6_wr_addr", b1.mem_addr, 10'h006);
    tick();
    chk("t6_wr_ack", b1.cpu_ack, 1);
    chk("t6_cpu_rdata_kept", b1.cpu_rdata, 16'h1234);
    chk("t6_host_rdata_kept", b1.host_rdata, 16'hA0A0);
    b1.cpu_req = 0;
    tick();

    // 4: reset during WAIT of a host read abandons it
    b1.host_req = 1; b1.host_we = 0; b1.host_addr = 10'h010;
    tick();
    chk("t4_access_en", b1.mem_en, 1);
    tick();
    chk("t4_wait_busy", {b1.busy, b1.mem_en}, 2'b10);
    reset = 1'b1;
    tick();
    chk("t4_busy", b1.busy, 0);
    chk("t4_host_ack", b1.host_ack, 0);
    chk("t4_mem", {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata}, 0);
    chk("t4_owner", b1.owner, 0);
    chk("t4_rdata", {b1.cpu_rdata, b1.host_rdata}, 0);
    reset = 1'b0;
    b1.host_req = 0;
    hs = 0;
    repeat (6) begin tick(); hs += int'(b1.host_ack); end
    chk("t4_no_late_ack", hs, 0);
    do_access(1'b0, 1'b1, 10'h007, 16'h7777, lat, n_en);
    chk("t4_wr_lat", lat, 2);
    chk("t4_wr_en", n_en, 1);

    // 5: MEM_LAT=3 instance, CPU read then host read of 0x3FF
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 10'h011;
    t = 0;
    do begin tick(); t++; end while (!b3.cpu_ack && t < 20);
    chk("t5_cpu_lat", t, 5);
    chk("t5_cpu_rdata", b3.cpu_rdata, 16'h0A11);
    b3.cpu_req = 0;
    tick();
    b3.host_req = 1; b3.host_we = 0; b3.host_addr = 10'h3FF;
    t = 0; te = 0;
    do begin
      tick();
      t++;
      if (b3.mem_en) te = t;
    end while (!b3.host_ack && t < 20);
    chk("t5_en_tick", te, 1);
    chk("t5_host_lat", t, 5);
    chk("t5_host_rdata", b3.host_rdata, 16'hBEEF);
    chk("t5_cpu_rdata_kept", b3.cpu_rdata, 16'h0A11);
    chk("t5_cpu_ack", b3.cpu_ack, 0);
    b3.host_req = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port 16-bit data memory between two requesters: the CPU load/store path of control_and_datapath and a host/loader port used for program/data loading and debug inspection.
- Serialises one access at a time through a small FSM.
- Uses round-robin arbitration, with a host lock override.
- Returns a one-cycle ack with read data to the winner.

Parameters:
ADDR_W, 10, word address width (matches PC/memory depth)
DATA_W, 16, data word width
MEM_LAT, 1, memory read latency in cycles; legal 1..3

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), freezes the CPU
host_req  in  1  host access request; held until host_ack
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_lock  in  1  when 1, CPU is never granted
host_ack  out  1  one-cycle completion pulse to host
host_rdata  out  DATA_W  host read data, valid with host_ack
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable; only high with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
owner  out  1  0=CPU, 1=host; current/last granted requester
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: on any edge with reset=1:
  - FSM goes to IDLE.
  - All outputs go to 0 (mem_en, mem_we, mem_addr, mem_wdata, acks, rdata, owner, busy).
  - last_owner is set to host, so the CPU wins the first tie.
  - An in-flight access is abandoned; no ack is issued for it.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - Eligible requesters: cpu_req & ~host_lock, and host_req.
  - None eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one that is not last_owner.
  - On grant: latch we/addr/wdata into mem_* registers, set owner and last_owner, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1, mem_we=latched we.
  - Write: go to ACK.
  - Read: go to WAIT with lat_cnt=MEM_LAT-1.
- WAIT:
  - mem_en=0.
  - Decrement lat_cnt each cycle.
  - When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to ACK.
  - The read therefore samples mem_rdata exactly MEM_LAT cycles after the mem_en cycle.
- ACK (exactly 1 cycle):
  - The owner's ack is high; rdata is stable.
  - No arbitration in this state; next state is IDLE.
  - The requester drops or changes req on this same edge.
- Latency, counted from the edge that samples req in IDLE:
  - Write: mem_en in cycle +1, ack in cycle +2.
  - Read: ack in cycle +2+MEM_LAT.
  - Back-to-back requests from one requester always spend one IDLE cycle between accesses.
- Signal holding rules:
  - Outside ACCESS: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
  - Writes never change either rdata register.
  - Each rdata register holds until that requester's next read completes.
- Latching and lock timing:
  - Request fields are latched at grant; input changes afterwards have no effect on the access.
  - host_lock is sampled only in IDLE; asserting it mid-access does not abort a CPU access.
- Invariants:
  - cpu_ack and host_ack are never high together.
  - At most one mem_en per grant.

Test Plan:
1. MEM_LAT=1. CPU write addr 0x005, data 0x1234 -> one cycle of mem_en=mem_we=1 with addr 0x005 / wdata 0x1234; cpu_ack 2 cycles after req; cpu_stall high until ack. Then CPU read 0x005 (bench memory model) -> mem_en with mem_we=0; cpu_ack 3 cycles after req; cpu_rdata=0x1234.
2. After reset, cpu_req and host_req both held continuously -> grant order CPU, host, CPU, host; owner alternates; acks never overlap; exactly one mem_en per ack.
3. host_lock=1, both requesting, 3 host reads -> three host_acks and no cpu_ack; cpu_stall held 1. Drop host_lock -> CPU granted at the next IDLE.
4. Reset pulsed during WAIT of a host read -> next cycle busy=0, all outputs 0, no host_ack ever for that read. After release with cpu_req=1 write -> normal 2-cycle ack.
5. MEM_LAT=3 host read of 0x3FF returning 0xBEEF -> host_ack 5 cycles after req; host_rdata=0xBEEF sampled 3 cycles after mem_en; cpu_rdata unchanged.
6. CPU read followed by CPU write while host idle -> host_rdata unchanged; after the write, cpu_rdata still holds the prior read value; one IDLE cycle between the two accesses.
